// File: rtl/deperforator_pkg.sv
// deperforator_pkg -- shared definitions for the depuncturer.
//   code_rate_e : i_code_rate encoding (2'd3 aliases rate 1/2)
//   PLEN_*      : puncture pattern lengths P
//   X_* / Y_*   : keep masks, bit k = pattern position k (1 = symbol sent)
//   phase_inc   : k+1 modulo P
package deperforator_pkg;

  typedef enum logic [1:0] {
    RATE_1_2     = 2'd0,
    RATE_3_4     = 2'd1,
    RATE_7_8     = 2'd2,
    RATE_1_2_ALT = 2'd3
  } code_rate_e;

  typedef enum logic {COLLECT, HOLD} state_e;

  localparam logic [2:0] PLEN_1_2 = 3'd1;
  localparam logic [2:0] PLEN_3_4 = 3'd3;
  localparam logic [2:0] PLEN_7_8 = 3'd7;

  // Written LSB-first: X=101 -> positions 0,2 ; Y=110 -> positions 0,1
  localparam logic [7:0] X_1_2 = 8'b0000_0001;
  localparam logic [7:0] Y_1_2 = 8'b0000_0001;
  localparam logic [7:0] X_3_4 = 8'b0000_0101;
  localparam logic [7:0] Y_3_4 = 8'b0000_0011;
  // X=1000101 -> positions 0,4,6 ; Y=1111010 -> positions 0,1,2,3,5
  localparam logic [7:0] X_7_8 = 8'b0101_0001;
  localparam logic [7:0] Y_7_8 = 8'b0010_1111;

  function automatic logic [2:0] phase_inc(input logic [2:0] k, input logic [2:0] plen);
    return (k + 3'd1 >= plen) ? 3'd0 : k + 3'd1;
  endfunction

endpackage

// File: rtl/deperforator_gen_if.sv
// deperforator_gen_if -- symbol stream in, depunctured pair stream out.
//   i_vld/o_rdy/i_data                : punctured symbol input handshake
//   o_vld/i_rdy/o_data_*/o_era_*      : X/Y pair output handshake
//   modport slave  : depuncturer side
//   modport master : upstream/downstream environment side
interface deperforator_gen_if #(
  parameter int D_WIDTH = 4
) ();
  logic               i_vld;
  logic               o_rdy;
  logic [D_WIDTH-1:0] i_data;
  logic               o_vld;
  logic               i_rdy;
  logic [D_WIDTH-1:0] o_data_x;
  logic [D_WIDTH-1:0] o_data_y;
  logic               o_era_x;
  logic               o_era_y;

  modport slave (
    input  i_vld, i_data, i_rdy,
    output o_rdy, o_vld, o_data_x, o_data_y, o_era_x, o_era_y
  );

  modport master (
    output i_vld, i_data, i_rdy,
    input  o_rdy, o_vld, o_data_x, o_data_y, o_era_x, o_era_y
  );
endinterface

// File: rtl/deperf_pattern_rom.sv
// deperf_pattern_rom -- combinational (rate, k) -> {need_x, need_y, P}.
//   rate   : code rate
//   k      : pattern position
//   need_x : X symbol present in the stream at k
//   need_y : Y symbol present in the stream at k
//   plen   : pattern length P for this rate
module deperf_pattern_rom
  import deperforator_pkg::*;
(
  input  code_rate_e rate,
  input  logic [2:0] k,
  output logic       need_x,
  output logic       need_y,
  output logic [2:0] plen
);
  always_comb begin
    case (rate)
      RATE_3_4: begin need_x = X_3_4[k]; need_y = Y_3_4[k]; plen = PLEN_3_4; end
      RATE_7_8: begin need_x = X_7_8[k]; need_y = Y_7_8[k]; plen = PLEN_7_8; end
      default:  begin need_x = X_1_2[k]; need_y = Y_1_2[k]; plen = PLEN_1_2; end
    endcase
  end
endmodule

// File: rtl/deperforator_gen.sv
// deperforator_gen -- depuncturer: rebuilds X/Y soft-symbol pairs from a
// punctured stream, filling dropped slots with ERASURE.
//   clk, reset_n : clock, async active-low reset
//   i_code_rate  : 0/3 = 1/2, 1 = 3/4, 2 = 7/8 (taken only at a pattern start)
//   i_slip       : pulse, drops partial/held state and skips one position
//   o_phase      : pattern position k of the pair being built/presented
//   bus          : symbol in / pair out handshakes (deperforator_gen_if.slave)
//   o_era_cnt    : saturating inserted-erasure count, only with
//                  DEPERFORATOR_GEN_STAT_EN defined
module deperforator_gen
  import deperforator_pkg::*;
#(
  parameter int                 D_WIDTH = 4,
  parameter logic [D_WIDTH-1:0] ERASURE = '0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] i_code_rate,
  input  logic       i_slip,
  output logic [2:0] o_phase,
`ifdef DEPERFORATOR_GEN_STAT_EN
  output logic [15:0] o_era_cnt,
`endif
  deperforator_gen_if.slave bus
);

  state_e             state;
  code_rate_e         rate_q, rate_eff;
  logic [2:0]         k, kc, plen_q, plen;
  logic               have_x, need_x, need_y;
  logic [D_WIDTH-1:0] xs_q;
  logic [D_WIDTH-1:0] dx_q, dy_q;
  logic               ex_q, ey_q;
  logic               pair_acc, in_acc, sample, take_x, done;

  assign bus.o_vld    = (state == HOLD);
  assign bus.o_rdy    = (state == COLLECT) | bus.i_rdy;
  assign bus.o_data_x = dx_q;
  assign bus.o_data_y = dy_q;
  assign bus.o_era_x  = ex_q;
  assign bus.o_era_y  = ey_q;
  assign o_phase      = k;

  assign pair_acc = (state == HOLD) & bus.i_rdy;
  assign in_acc   = bus.i_vld & bus.o_rdy;
  // A symbol arriving while the held pair leaves belongs to the next position.
  assign kc       = pair_acc ? phase_inc(k, plen_q) : k;
  // New rate only at a pattern boundary with nothing half-collected.
  assign sample   = (kc == 3'd0) & ~have_x;
  assign rate_eff = sample ? code_rate_e'(i_code_rate) : rate_q;

  deperf_pattern_rom u_rom (
    .rate   (rate_eff),
    .k      (kc),
    .need_x (need_x),
    .need_y (need_y),
    .plen   (plen)
  );

  // Current symbol is X when X is still owed; it completes the pair unless
  // a Y must follow it.
  assign take_x = need_x & ~have_x;
  assign done   = in_acc & ~(take_x & need_y);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= COLLECT;
      rate_q <= RATE_1_2;
      plen_q <= PLEN_1_2;
      k      <= '0;
      have_x <= 1'b0;
      xs_q   <= '0;
      dx_q   <= '0;
      dy_q   <= '0;
      ex_q   <= 1'b0;
      ey_q   <= 1'b0;
    end else if (i_slip) begin
      state  <= COLLECT;
      k      <= phase_inc(k, plen_q);
      have_x <= 1'b0;
    end else begin
      k <= kc;
      if (in_acc && sample) begin
        rate_q <= rate_eff;
        plen_q <= plen;
      end
      if (done) begin
        state  <= HOLD;
        have_x <= 1'b0;
        dx_q   <= take_x ? bus.i_data : (need_x ? xs_q : ERASURE);
        dy_q   <= need_y ? bus.i_data : ERASURE;
        ex_q   <= ~need_x;
        ey_q   <= ~need_y;
      end else begin
        if (pair_acc) state <= COLLECT;
        if (in_acc) begin
          have_x <= 1'b1;
          xs_q   <= bus.i_data;
        end
      end
    end
  end

`ifdef DEPERFORATOR_GEN_STAT_EN
  logic [15:0] era_cnt;
  logic [1:0]  era_add;
  assign era_add   = {1'b0, ~need_x} + {1'b0, ~need_y};
  assign o_era_cnt = era_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    era_cnt <= '0;
    else if (i_slip) era_cnt <= '0;
    else if (done) begin
      if (era_cnt > 16'hFFFF - 16'(era_add)) era_cnt <= 16'hFFFF;
      else                                   era_cnt <= era_cnt + 16'(era_add);
    end
  end
`endif

endmodule

// File: tb/tb_deperforator_gen.sv
// tb_deperforator_gen -- table vectors, hand-written corner sequences and a
// randomized run against a queue-based pattern model.
module tb_deperforator_gen;
  import deperforator_pkg::*;

  localparam int             DW = 4;
  localparam logic [DW-1:0]  E  = 4'hF;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] i_code_rate = 2'd0;
  logic       i_slip = 1'b0;
  logic [2:0] o_phase;
`ifdef DEPERFORATOR_GEN_STAT_EN
  logic [15:0] o_era_cnt;
`endif

  deperforator_gen_if #(.D_WIDTH(DW)) bus ();

  deperforator_gen #(.D_WIDTH(DW), .ERASURE(E)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_code_rate (i_code_rate),
    .i_slip      (i_slip),
    .o_phase     (o_phase),
`ifdef DEPERFORATOR_GEN_STAT_EN
    .o_era_cnt   (o_era_cnt),
`endif
    .bus         (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_pair(input string name, input int x, input int y,
                          input int ex, input int ey, input int ph);
    chk({name, "_vld"}, bus.o_vld, 1);
    chk({name, "_x"}, bus.o_data_x, x);
    chk({name, "_y"}, bus.o_data_y, y);
    chk({name, "_ex"}, bus.o_era_x, ex);
    chk({name, "_ey"}, bus.o_era_y, ey);
    chk({name, "_ph"}, o_phase, ph);
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_vld"}, bus.o_vld, 0);
    chk({name, "_x"}, bus.o_data_x, 0);
    chk({name, "_y"}, bus.o_data_y, 0);
    chk({name, "_ex"}, bus.o_era_x, 0);
    chk({name, "_ey"}, bus.o_era_y, 0);
    chk({name, "_ph"}, o_phase, 0);
    chk({name, "_rdy"}, bus.o_rdy, 1);
  endtask

  task automatic do_reset();
    reset_n = 1'b0; i_slip = 1'b0;
    bus.i_vld = 1'b0; bus.i_rdy = 1'b1; bus.i_data = '0;
    tick();
    reset_n = 1'b1;
  endtask

  task automatic push(input int d);
    bus.i_vld = 1'b1; bus.i_data = DW'(d);
    tick();
    bus.i_vld = 1'b0;
  endtask

  // ---------------- table vectors ----------------
  typedef struct {
    bit rst; int rate; bit vld; int d;
    bit ev; int ex_d; int ey_d; int eex; int eey; int eph;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit rst, int rate, bit vld, int d, bit ev,
                              int x, int y, int ex, int ey, int ph);
    vec_t v;
    v.rst = rst; v.rate = rate; v.vld = vld; v.d = d; v.ev = ev;
    v.ex_d = x; v.ey_d = y; v.eex = ex; v.eey = ey; v.eph = ph;
    return v;
  endfunction

  // ---------------- reference model ----------------
  function automatic int plen_of(int r);
    return (r == 1) ? 3 : (r == 2) ? 7 : 1;
  endfunction

  function automatic int need(int r, int k, bit y);
    string s;
    case (r)
      1:       s = y ? "110" : "101";
      2:       s = y ? "1111010" : "1000101";
      default: s = "1";
    endcase
    return (s.getc(k) == "1") ? 1 : 0;
  endfunction

  int            m_k, m_rate, m_cnt;
  bit            m_pend;
  int            m_x, m_y, m_ex, m_ey;
  logic [DW-1:0] m_part[$];

  task automatic model_reset();
    m_k = 0; m_rate = 0; m_cnt = 0; m_pend = 0; m_part.delete();
  endtask

  task automatic model_step(input int rate, input bit slip, input bit vld,
                            input int d, input bit rdy);
    int nx, ny;
    bit acc;
    acc = vld && (!m_pend || rdy);
    if (slip) begin
      m_part.delete(); m_pend = 0; m_cnt = 0;
      m_k = (m_k + 1) % plen_of(m_rate);
    end else begin
      if (m_pend && rdy) begin
        m_pend = 0;
        m_k = (m_k + 1) % plen_of(m_rate);
      end
      if (acc) begin
        if (m_k == 0 && m_part.size() == 0) m_rate = (rate == 3) ? 0 : rate;
        nx = need(m_rate, m_k, 1'b0);
        ny = need(m_rate, m_k, 1'b1);
        m_part.push_back(DW'(d));
        if (m_part.size() == nx + ny) begin
          m_x  = nx ? int'(m_part[0]) : int'(E);
          m_y  = ny ? int'(m_part[nx]) : int'(E);
          m_ex = !nx; m_ey = !ny;
          m_pend = 1;
          m_cnt = m_cnt + m_ex + m_ey;
          if (m_cnt > 65535) m_cnt = 65535;
          m_part.delete();
        end
      end
    end
  endtask

  initial begin
    bus.i_vld = 1'b0; bus.i_rdy = 1'b1; bus.i_data = '0;

    // rate 1/2
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 2, 1, 1, 2, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 3, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 4, 1, 3, 4, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // rate 3/4
    tbl.push_back(mk(0, 1, 1, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 2, 1, 1, 2, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 3, 1, E, 3, 1, 0, 1));
    tbl.push_back(mk(0, 1, 1, 4, 1, 4, E, 0, 1, 2));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    // rate 7/8, fresh from reset
    tbl.push_back(mk(1, 2, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 2, 1, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 2, 1, 2, 1, 1, 2, 0, 0, 0));
    tbl.push_back(mk(0, 2, 1, 3, 1, E, 3, 1, 0, 1));
    tbl.push_back(mk(0, 2, 1, 4, 1, E, 4, 1, 0, 2));
    tbl.push_back(mk(0, 2, 1, 5, 1, E, 5, 1, 0, 3));
    tbl.push_back(mk(0, 2, 1, 6, 1, 6, E, 0, 1, 4));
    tbl.push_back(mk(0, 2, 1, 7, 1, E, 7, 1, 0, 5));
    tbl.push_back(mk(0, 2, 1, 8, 1, 8, E, 0, 1, 6));
    tbl.push_back(mk(0, 2, 0, 0, 0, 0, 0, 0, 0, 0));

    foreach (tbl[i]) begin
      if (tbl[i].rst) reset_n = 1'b0;
      i_code_rate = 2'(tbl[i].rate);
      bus.i_vld   = tbl[i].vld;
      bus.i_data  = DW'(tbl[i].d);
      bus.i_rdy   = 1'b1;
      tick();
      chk($sformatf("tbl%0d_vld", i), bus.o_vld, tbl[i].ev);
      chk($sformatf("tbl%0d_ph", i), o_phase, tbl[i].eph);
      chk($sformatf("tbl%0d_rdy", i), bus.o_rdy, 1);
      if (tbl[i].ev || tbl[i].rst) begin
        chk($sformatf("tbl%0d_x", i), bus.o_data_x, tbl[i].ex_d);
        chk($sformatf("tbl%0d_y", i), bus.o_data_y, tbl[i].ey_d);
        chk($sformatf("tbl%0d_ex", i), bus.o_era_x, tbl[i].eex);
        chk($sformatf("tbl%0d_ey", i), bus.o_era_y, tbl[i].eey);
      end
      reset_n = 1'b1;
    end
`ifdef DEPERFORATOR_GEN_STAT_EN
    chk("era_cnt_7_8", o_era_cnt, 6);
`endif

    // ---------------- backpressure at rate 3/4 ----------------
    do_reset();
    i_code_rate = 2'd1;
    push(1); push(2);
    chk_pair("stall_p0", 1, 2, 0, 0, 0);
    bus.i_rdy = 1'b0; bus.i_vld = 1'b1; bus.i_data = 4'd3;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk_pair($sformatf("stall_c%0d", c), 1, 2, 0, 0, 0);
      chk($sformatf("stall_c%0d_rdy", c), bus.o_rdy, 0);
    end
    bus.i_rdy = 1'b1;
    tick();
    chk_pair("stall_p1", E, 3, 1, 0, 1);
    bus.i_data = 4'd4;
    tick();
    chk_pair("stall_p2", 4, E, 0, 1, 2);
    bus.i_vld = 1'b0;
    tick();
    chk("stall_end_vld", bus.o_vld, 0);
    chk("stall_end_ph", o_phase, 0);

    // ---------------- slip with X held, colliding input dropped ----------------
    do_reset();
    i_code_rate = 2'd1;
    push(1);
    chk("slip_pre_vld", bus.o_vld, 0);
    i_slip = 1'b1; bus.i_vld = 1'b1; bus.i_data = 4'd9;
    tick();
    i_slip = 1'b0; bus.i_vld = 1'b0;
    chk("slip_vld", bus.o_vld, 0);
    chk("slip_ph", o_phase, 1);
    push(5);
    chk_pair("slip_p1", E, 5, 1, 0, 1);
    push(6);
    chk_pair("slip_p2", 6, E, 0, 1, 2);
`ifdef DEPERFORATOR_GEN_STAT_EN
    chk("slip_era_cnt", o_era_cnt, 2);
`endif

    // ---------------- reset mid-pattern at 7/8, k=4 ----------------
    do_reset();
    i_code_rate = 2'd2;
    for (int s = 1; s <= 5; s++) push(s);
    chk_pair("mid_p3", E, 5, 1, 0, 3);
    tick();
    chk("mid_k4_vld", bus.o_vld, 0);
    chk("mid_k4_ph", o_phase, 4);
    reset_n = 1'b0;
    #1;
    chk_zero("mid_async");
    tick();
    reset_n = 1'b1;
    chk_zero("mid_rel");
    // Rate 1/2 (P=1) still in force: a slip leaves k at 0.
    i_slip = 1'b1;
    tick();
    i_slip = 1'b0;
    chk("mid_slip_ph", o_phase, 0);
    push(1); push(2);
    chk_pair("mid_n0", 1, 2, 0, 0, 0);
    push(3);
    chk_pair("mid_n1", E, 3, 1, 0, 1);

    // ---------------- randomized run ----------------
    do_reset();
    model_reset();
    i_code_rate = 2'(0);
    for (int cyc = 0; cyc < 4000; cyc++) begin
      int  r, d;
      bit  sl, v, rd;
      if ($urandom_range(0, 39) == 0) i_code_rate = 2'($urandom_range(0, 3));
      r  = int'(i_code_rate);
      sl = ($urandom_range(0, 29) == 0);
      v  = ($urandom_range(0, 3) != 0);
      rd = ($urandom_range(0, 3) != 0);
      d  = int'($urandom_range(0, 15));
      i_slip = sl; bus.i_vld = v; bus.i_rdy = rd; bus.i_data = DW'(d);
      #1;
      chk("rnd_rdy", bus.o_rdy, (!m_pend || rd) ? 1 : 0);
      model_step(r, sl, v, d, rd);
      @(posedge clk);
      #1;
      chk("rnd_vld", bus.o_vld, m_pend);
      chk("rnd_ph", o_phase, m_k);
      if (m_pend) begin
        chk("rnd_x", bus.o_data_x, m_x);
        chk("rnd_y", bus.o_data_y, m_y);
        chk("rnd_ex", bus.o_era_x, m_ex);
        chk("rnd_ey", bus.o_era_y, m_ey);
      end
`ifdef DEPERFORATOR_GEN_STAT_EN
      chk("rnd_cnt", o_era_cnt, m_cnt);
`endif
    end
    i_slip = 1'b0; bus.i_vld = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/deperforator_gen.md
DEPERFORATOR_GEN -- requirements
Module: deperforator_gen

Interface
REQ-001 SHALL have parameter D_WIDTH, default 4, soft-symbol width in bits (2..8).
REQ-002 SHALL have parameter ERASURE, default 0, D_WIDTH-bit value written into punctured positions.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port i_code_rate  input  2  2'd0 = 1/2, 2'd1 = 3/4, 2'd2 = 7/8, 2'd3 = 1/2.
REQ-006 SHALL have port i_slip  input  1  one-cycle pulse; advances puncture phase by one position.
REQ-007 SHALL have port i_vld  input  1  input symbol valid.
REQ-008 SHALL have port o_rdy  output  1  block can accept an input symbol.
REQ-009 SHALL have port i_data  input  D_WIDTH  punctured soft symbol.
REQ-010 SHALL have port o_vld  output  1  output pair valid.
REQ-011 SHALL have port i_rdy  input  1  downstream accepts the pair.
REQ-012 SHALL have ports o_data_x and o_data_y  output  D_WIDTH each  depunctured G1/G2 soft symbols.
REQ-013 SHALL have ports o_era_x and o_era_y  output  1 each  high when the matching output is an inserted erasure.
REQ-014 SHALL have port o_phase  output  3  current pattern position k.

Function
REQ-015 SHALL use patterns X/Y per rate (k = 0..P-1): 1/2: X=1, Y=1 (P=1); 3/4: X=101, Y=110 (P=3); 7/8: X=1000101, Y=1111010 (P=7).
REQ-016 SHALL, at each position k, consume the X symbol (if present) before the Y symbol (if present) from the input stream.
REQ-017 SHALL fill each punctured slot with ERASURE and set the matching o_era_* flag.
REQ-018 SHALL accept an input symbol only on a cycle where i_vld and o_rdy are both high.
REQ-019 SHALL assert o_vld the cycle after the last symbol required by position k is accepted (latency 1).
REQ-020 SHALL hold o_data_*, o_era_* and o_vld stable while o_vld=1 and i_rdy=0.
REQ-021 SHALL drive o_rdy = !o_vld | i_rdy, so a pair is accepted and the next symbol taken in the same cycle without a bubble.
REQ-022 SHALL advance k modulo P on each accepted pair and wrap from P-1 to 0.
REQ-023 SHALL sample i_code_rate only when k=0 with no partial symbol held; a change mid-pattern takes effect at the next wrap.
REQ-024 SHALL, on i_slip, discard any held partial symbol and any unaccepted output pair, clear o_vld, and set k to (k+1) mod P in the next cycle.
REQ-025 SHALL, when i_slip and an input handshake occur in the same cycle, give priority to i_slip and drop that symbol.
REQ-026 SHALL implement a two-state FSM: COLLECT (gathering X/Y for position k) and HOLD (pair presented, waiting for i_rdy); HOLD->COLLECT on i_rdy or i_slip.

Reset
REQ-027 SHALL, while reset_n=0, clear o_vld, o_data_x, o_data_y, o_era_x, o_era_y and o_phase to 0, select rate 1/2, and enter COLLECT; o_rdy SHALL be 1 after release.
REQ-028 SHALL, on reset mid-pattern, discard all partial state with no output produced.

Configuration
REQ-029 SHALL, with DEPERFORATOR_GEN_STAT_EN defined, add output o_era_cnt (16 bits, saturating at 16'hFFFF) counting inserted erasures, reset to 0 and cleared by i_slip.
REQ-030 SHALL, without DEPERFORATOR_GEN_STAT_EN defined, omit o_era_cnt and its logic entirely.

Structure
REQ-031 SHALL place the code-rate enum, the pattern length constants (1/3/7) and the X/Y pattern masks in shared package deperforator_pkg.
REQ-032 SHALL put the (rate, k) -> {need_x, need_y, P} lookup in combinational sub-module deperf_pattern_rom.

Verification
REQ-033 Rate 1/2, inputs 1,2,3,4, i_rdy=1 -> pairs (1,2),(3,4); no era flags; o_phase stays 0.
REQ-034 Rate 3/4, inputs 1,2,3,4 -> pairs (1,2),(E,3),(4,E) with E=ERASURE; era flags 00,10,01; o_phase 0,1,2,0.
REQ-035 Rate 7/8, 8 inputs 1..8 -> 7 pairs (1,2),(E,3),(E,4),(E,5),(6,E),(E,7),(8,E); o_era_cnt=6 when STAT_EN is defined.
REQ-036 Rate 3/4, i_rdy=0 for 5 cycles while a pair is held -> o_vld and data stable, o_rdy=0, no symbol lost once i_rdy=1.
REQ-037 Rate 3/4 at k=0 with X held, pulse i_slip -> partial symbol dropped, o_phase=1, next input emitted as (E,sym).
REQ-038 Assert reset_n=0 mid-pattern at rate 7/8, k=4 -> all outputs 0 and o_rdy=1 after release, rate 1/2 applied until k=0 resample.
